pixel_unpack: RTL and testbench
===============================

Name: pixel_unpack

Overview:
- Sits between the SDRAM read-side word FIFO and the HDMI pixel front end.
- Consumes 16-bit packed words and emits one 24-bit RGB pixel per pixel request.
- Unpacks 1-bit, 8-bit and RGB565 formats according to PIXEL_MODE, and pops words only when the current word is exhausted.
- Tracks pixels per frame and flags FIFO underrun.

Parameters:
- FRAME_PIXELS, 307200: pixels per frame (640x480).
- PIX_CNT_W, 19: width of the frame pixel counter; must satisfy 2^PIX_CNT_W > FRAME_PIXELS.

Ports:
- CLK  in  1  pixel clock, 25 MHz.
- RESET_N  in  1  synchronous reset, active-low.
- PIXEL_MODE  in  2  00 legacy 8-bit (1 px/word), 01 1-bit (16 px/word), 10 8-bit (2 px/word), 11 RGB565 (1 px/word).
- FRAME_SYNC  in  1  vertical sync level from the HDMI timing block; the rising edge starts a frame.
- PIX_REQ  in  1  pixel request from HDMI (oRequest); one pixel per cycle while high.
- WORD_DATA  in  16  show-ahead FIFO head word; valid while WORD_EMPTY=0.
- WORD_EMPTY  in  1  FIFO empty.
- WORD_RD  out  1  FIFO pop strobe; combinational.
- oRED  out  8  red.
- oGREEN  out  8  green.
- oBLUE  out  8  blue.
- oVALID  out  1  pixel outputs valid.
- UNDERRUN  out  1  sticky underrun flag; cleared at frame start.
- FRAME_DONE  out  1  high once FRAME_PIXELS pixels have been emitted.

Behaviour:
- Reset (RESET_N=0 at a CLK edge): state=WAIT_FRAME, oRED/oGREEN/oBLUE=0, oVALID=0, UNDERRUN=0, FRAME_DONE=0, hold_valid=0, sub_idx=0, pix_cnt=0, latched mode=00. WORD_RD=0 while in reset.
- FRAME_SYNC is edge-detected with one register; a rise is the cycle where FRAME_SYNC=1 and the previous sample was 0.
- States:
  - WAIT_FRAME: no pops; outputs black, oVALID=0. On FRAME_SYNC rise go to ACTIVE.
  - ACTIVE: serve requests. Go to DONE when the FRAME_PIXELS-th pixel is emitted.
  - DONE: FRAME_DONE=1; no pops; requests answered black with oVALID=0. On FRAME_SYNC rise go to ACTIVE.
- FRAME_SYNC rise in any state:
  - latch PIXEL_MODE;
  - clear hold_valid, sub_idx, pix_cnt, UNDERRUN and FRAME_DONE;
  - discard the held word without popping the FIFO.
- PIXEL_MODE changes mid-frame are ignored.
- Pixel source: src = hold_valid ? hold_word : WORD_DATA.
- need_word = !hold_valid.
- WORD_RD = ACTIVE & PIX_REQ & need_word & !WORD_EMPTY & !sync_rise.
- On a pop with a multi-pixel mode: hold_word<=WORD_DATA, hold_valid<=1, sub_idx<=1.
- Otherwise sub_idx increments. When sub_idx reaches the last index for the mode, hold_valid<=0 and sub_idx<=0, so the next request pops.
- Mode 00/11 never sets hold_valid.
- Latency: PIX_REQ in cycle n gives registered oRED/oGREEN/oBLUE and oVALID=1 in cycle n+1. oVALID=0 in any cycle not preceded by a request in ACTIVE.
- Unpacking:
  - 00: R=G=B=src[7:0].
  - 01: pixel k uses src[15-k], k=0..15; 1 -> 8'hFF, 0 -> 8'h00 on all channels.
  - 10: k=0 -> src[7:0], k=1 -> src[15:8]; gray on all channels.
  - 11 (byte-swapped RGB565): R5=src[7:3], G6={src[2:0],src[15:13]}, B5=src[12:8].
  - RGB565 expansion: R={R5,R5[4:2]}, G={G6,G6[5:4]}, B={B5,B5[4:2]}.
- Underrun: PIX_REQ in ACTIVE with need_word & WORD_EMPTY.
  - No pop; emit black with oVALID=1.
  - UNDERRUN<=1 (sticky).
  - pix_cnt still increments, so frame length is preserved.
- pix_cnt increments on every served request in ACTIVE. The pixel at pix_cnt==FRAME_PIXELS-1 is emitted, then state<=DONE.
- PIX_REQ coincident with a FRAME_SYNC rise: the request is dropped (no pop, oVALID=0 next cycle); the frame starts clean.
- Reset mid-word: the held word is lost and the FIFO is untouched. The SDRAM side restarts its read pointer on vSYNC.

Optional Feature:
- Macro UNDERRUN_HOLD_EN.
- Defined: on underrun, repeat the last emitted RGB value (reset/frame-start value black) instead of black; the UNDERRUN flag is unchanged.
- Undefined: an underrun pixel is black.

Test Plan:
- Mode 11, FRAME_SYNC rise, FIFO holds 16'h1CF8, one PIX_REQ -> next cycle R=8'hFF, G=8'h00 (bits 000 000), B=8'h1C->B5=11100 -> B=8'hE7; WORD_RD pulses once.
- Mode 01, word 16'hA000, 16 consecutive PIX_REQ -> pixels FF,00,FF,00 then twelve 00; exactly one WORD_RD, in the first request cycle; the 17th request pops the next word.
- Mode 10, word 16'h80_40, 2 requests -> gray 8'h40 then 8'h80; second word popped on the third request.
- FIFO empty with PIX_REQ high for 3 cycles in ACTIVE -> 3 black pixels with oVALID=1, UNDERRUN=1 held until the next FRAME_SYNC rise clears it. With UNDERRUN_HOLD_EN, the 3 pixels equal the last emitted pixel.
- FRAME_PIXELS=8 override, mode 00, 10 requests -> 8 valid pixels, FRAME_DONE=1 after the 8th, requests 9-10 give oVALID=0 and no pops.
- FRAME_SYNC rise while mode 01 is mid-word (sub_idx=5), PIXEL_MODE changed to 11 -> held word discarded, the next request pops a fresh word decoded as RGB565; RESET_N=0 for one cycle mid-frame -> all outputs 0, state WAIT_FRAME.

Source files
------------

// File: rtl/pixel_unpack.sv
// Unpacks 16-bit FIFO words into 24-bit RGB pixels (1-bit, 8-bit, RGB565 modes) with frame tracking.
// Optional UNDERRUN_HOLD_EN: an underrun pixel repeats the last emitted RGB value instead of black.
module pixel_unpack #(
   parameter int FRAME_PIXELS = 307200,
   parameter int PIX_CNT_W    = 19
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [1:0]  PIXEL_MODE,
   input  logic        FRAME_SYNC,
   input  logic        PIX_REQ,
   input  logic [15:0] WORD_DATA,
   input  logic        WORD_EMPTY,
   output logic        WORD_RD,
   output logic [7:0]  oRED,
   output logic [7:0]  oGREEN,
   output logic [7:0]  oBLUE,
   output logic        oVALID,
   output logic        UNDERRUN,
   output logic        FRAME_DONE,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACTIVE     = 2'd1,
      DONE       = 2'd2
   } state_t;

   localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

   state_t                 state_q, state_d;
   logic                   fs_prev_q;
   logic [1:0]             mode_q, mode_d;
   logic [15:0]            hold_word_q, hold_word_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [3:0]             sub_idx_q, sub_idx_d;
   logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [23:0]            rgb_q, rgb_d;
   logic                   valid_q, valid_d;
   logic                   underrun_q, underrun_d;
   logic                   done_q, done_d;
`ifdef UNDERRUN_HOLD_EN
   logic [23:0]            last_q, last_d;
`endif

   logic        sync_rise, need_word, serve, starve, multi;
   logic [3:0]  last_idx, k;
   logic [15:0] src;
   logic [23:0] pix;
   logic [4:0]  r5, b5;
   logic [5:0]  g6;
   logic [7:0]  gray;

   assign sync_rise = FRAME_SYNC & ~fs_prev_q;
   assign need_word = ~hold_valid_q;
   // A request coincident with frame start is dropped so the new frame starts clean.
   assign serve     = (state_q == ACTIVE) & PIX_REQ & ~sync_rise;
   assign starve    = serve & need_word & WORD_EMPTY;
   assign WORD_RD   = RESET_N & serve & need_word & ~WORD_EMPTY;
   assign src       = hold_valid_q ? hold_word_q : WORD_DATA;
   assign k         = hold_valid_q ? sub_idx_q : 4'd0;
   assign multi     = (mode_q == 2'b01) | (mode_q == 2'b10);
   assign last_idx  = (mode_q == 2'b01) ? 4'd15 : 4'd1;

   always_comb begin
      pix  = 24'h0;
      r5   = 5'h0;
      g6   = 6'h0;
      b5   = 5'h0;
      gray = 8'h0;
      case (mode_q)
         2'b00: pix = {3{src[7:0]}};
         2'b01: pix = src[4'd15 - k] ? 24'hFFFFFF : 24'h000000;
         2'b10: begin
            gray = k[0] ? src[15:8] : src[7:0];
            pix  = {3{gray}};
         end
         default: begin
            // Byte-swapped RGB565: low byte carries R and the top of G.
            r5  = src[7:3];
            g6  = {src[2:0], src[15:13]};
            b5  = src[12:8];
            pix = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      hold_word_d  = hold_word_q;
      hold_valid_d = hold_valid_q;
      sub_idx_d    = sub_idx_q;
      pix_cnt_d    = pix_cnt_q;
      rgb_d        = 24'h0;
      valid_d      = 1'b0;
      underrun_d   = underrun_q;
      done_d       = done_q;
`ifdef UNDERRUN_HOLD_EN
      last_d       = last_q;
`endif
      if (sync_rise) begin
         state_d      = ACTIVE;
         mode_d       = PIXEL_MODE;
         hold_valid_d = 1'b0;
         sub_idx_d    = 4'd0;
         pix_cnt_d    = '0;
         underrun_d   = 1'b0;
         done_d       = 1'b0;
`ifdef UNDERRUN_HOLD_EN
         last_d       = 24'h0;
`endif
      end else if (serve) begin
         valid_d   = 1'b1;
         pix_cnt_d = pix_cnt_q + 1'b1;
         if (pix_cnt_q == LAST_PIX) begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         if (starve) begin
            underrun_d = 1'b1;
`ifdef UNDERRUN_HOLD_EN
            rgb_d      = last_q;
`else
            rgb_d      = 24'h0;
`endif
         end else begin
            rgb_d = pix;
`ifdef UNDERRUN_HOLD_EN
            last_d = pix;
`endif
            if (need_word) begin
               if (multi) begin
                  hold_word_d  = WORD_DATA;
                  hold_valid_d = 1'b1;
                  sub_idx_d    = 4'd1;
               end
            end else if (sub_idx_q == last_idx) begin
               hold_valid_d = 1'b0;
               sub_idx_d    = 4'd0;
            end else begin
               sub_idx_d = sub_idx_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q      <= WAIT_FRAME;
         fs_prev_q    <= 1'b0;
         mode_q       <= 2'b00;
         hold_word_q  <= 16'h0;
         hold_valid_q <= 1'b0;
         sub_idx_q    <= 4'd0;
         pix_cnt_q    <= '0;
         rgb_q        <= 24'h0;
         valid_q      <= 1'b0;
         underrun_q   <= 1'b0;
         done_q       <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
         last_q       <= 24'h0;
`endif
      end else begin
         state_q      <= state_d;
         fs_prev_q    <= FRAME_SYNC;
         mode_q       <= mode_d;
         hold_word_q  <= hold_word_d;
         hold_valid_q <= hold_valid_d;
         sub_idx_q    <= sub_idx_d;
         pix_cnt_q    <= pix_cnt_d;
         rgb_q        <= rgb_d;
         valid_q      <= valid_d;
         underrun_q   <= underrun_d;
         done_q       <= done_d;
`ifdef UNDERRUN_HOLD_EN
         last_q       <= last_d;
`endif
      end
   end

   assign oRED        = rgb_q[23:16];
   assign oGREEN      = rgb_q[15:8];
   assign oBLUE       = rgb_q[7:0];
   assign oVALID      = valid_q;
   assign UNDERRUN    = underrun_q;
   assign FRAME_DONE  = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pixel_unpack.sv
// Directed bench for pixel_unpack: FIFO model, expected-pixel queue, and a monitor on oVALID.
module tb_pixel_unpack;

   localparam int FP = 32;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [1:0]  PIXEL_MODE;
   logic        FRAME_SYNC;
   logic        PIX_REQ;
   logic [15:0] WORD_DATA;
   logic        WORD_EMPTY;
   logic        WORD_RD;
   logic [7:0]  oRED, oGREEN, oBLUE;
   logic        oVALID, UNDERRUN, FRAME_DONE;
   logic [1:0]  dbg_state;

   always #20 CLK = ~CLK;

   pixel_unpack #(.FRAME_PIXELS(FP), .PIX_CNT_W(6)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .PIXEL_MODE(PIXEL_MODE), .FRAME_SYNC(FRAME_SYNC),
      .PIX_REQ(PIX_REQ), .WORD_DATA(WORD_DATA), .WORD_EMPTY(WORD_EMPTY), .WORD_RD(WORD_RD),
      .oRED(oRED), .oGREEN(oGREEN), .oBLUE(oBLUE), .oVALID(oVALID), .UNDERRUN(UNDERRUN),
      .FRAME_DONE(FRAME_DONE), .dbg_state_o(dbg_state)
   );

   // Show-ahead FIFO model: head word visible combinationally, popped on WORD_RD.
   logic [15:0] fifo_mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign WORD_EMPTY = (wr_ptr == rd_ptr);
   assign WORD_DATA  = fifo_mem[rd_ptr % 64];
   always @(posedge CLK) if (RESET_N && WORD_RD) rd_ptr <= rd_ptr + 1;

   int n_checks = 0;
   int n_fails  = 0;
   logic [23:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic push_word(input logic [15:0] w);
      fifo_mem[wr_ptr % 64] = w;
      wr_ptr++;
   endtask

   task automatic flush();
      wr_ptr = rd_ptr;
   endtask

   task automatic frame_start(input logic [1:0] m);
      PIXEL_MODE = m;
      FRAME_SYNC = 1'b1;
      tick();
      FRAME_SYNC = 1'b0;
   endtask

   task automatic req(input logic [23:0] e);
      PIX_REQ = 1'b1;
      exp_q.push_back(e);
      tick();
      PIX_REQ = 1'b0;
   endtask

   task automatic req_drop();
      PIX_REQ = 1'b1;
      tick();
      PIX_REQ = 1'b0;
   endtask

   logic [23:0] under_px;
   logic [7:0]  b;
   int          base;

   initial begin
      RESET_N    = 1'b0;
      PIXEL_MODE = 2'b00;
      FRAME_SYNC = 1'b0;
      PIX_REQ    = 1'b0;

      fork
         forever begin
            @(negedge CLK);
            if (oVALID) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fails++;
                  $display("FAIL unexpected_pixel: got %06h expected no valid pixel", {oRED, oGREEN, oBLUE});
               end else begin
                  check("pixel", {8'h0, oRED, oGREEN, oBLUE}, {8'h0, exp_q.pop_front()});
               end
            end
         end
      join_none

      // Reset state
      repeat (3) tick();
      check("rst_rgb", {8'h0, oRED, oGREEN, oBLUE}, 32'h0);
      check("rst_valid", oVALID, 0);
      check("rst_underrun", UNDERRUN, 0);
      check("rst_done", FRAME_DONE, 0);
      check("rst_state", dbg_state, 0);
      check("rst_rd", WORD_RD, 0);
      RESET_N = 1'b1;
      tick();

      // WAIT_FRAME ignores requests and does not pop
      push_word(16'h00AA);
      req_drop();
      req_drop();
      check("wait_pops", rd_ptr, 0);
      check("wait_state", dbg_state, 0);

      // Mode 11 RGB565: 1CF8 -> FF,00,E7
      flush();
      push_word(16'h1CF8);
      base = rd_ptr;
      frame_start(2'b11);
      check("active_state", dbg_state, 1);
      PIX_REQ = 1'b1;
      exp_q.push_back(24'hFF00E7);
      #1 check("rd_mode11", WORD_RD, 1);
      tick();
      PIX_REQ = 1'b0;
      check("pops_mode11", rd_ptr, base + 1);

      // Mode 01: A000 gives FF,00,FF,00 then zeros; 17th request pops the next word
      flush();
      push_word(16'hA000);
      push_word(16'h5555);
      base = rd_ptr;
      frame_start(2'b01);
      PIX_REQ = 1'b1;
      exp_q.push_back(24'hFFFFFF);
      #1 check("rd_mode01_first", WORD_RD, 1);
      tick();
      for (int i = 1; i < 16; i++) req((i == 2) ? 24'hFFFFFF : 24'h000000);
      check("pops_mode01_16", rd_ptr, base + 1);
      req(24'h000000);
      check("pops_mode01_17", rd_ptr, base + 2);

      // Mode 10: 8040 -> 40 then 80; mid-frame mode change ignored
      flush();
      push_word(16'h8040);
      push_word(16'h1234);
      base = rd_ptr;
      frame_start(2'b10);
      req(24'h404040);
      PIXEL_MODE = 2'b00;
      req(24'h808080);
      check("pops_mode10_2", rd_ptr, base + 1);
      req(24'h343434);
      check("pops_mode10_3", rd_ptr, base + 2);

      // Underrun: empty FIFO for 3 requests
      flush();
      push_word(16'h0055);
      base = rd_ptr;
      frame_start(2'b00);
      req(24'h555555);
      check("underrun_clear", UNDERRUN, 0);
`ifdef UNDERRUN_HOLD_EN
      under_px = 24'h555555;
`else
      under_px = 24'h000000;
`endif
      repeat (3) req(under_px);
      check("underrun_set", UNDERRUN, 1);
      check("pops_underrun", rd_ptr, base + 1);
      repeat (3) tick();
      check("underrun_sticky", UNDERRUN, 1);
      frame_start(2'b00);
      check("underrun_cleared_by_sync", UNDERRUN, 0);

      // Frame length: FP pixels then DONE, extra requests ignored
      flush();
      for (int i = 0; i < FP + 2; i++) push_word(16'(i + 1));
      base = rd_ptr;
      frame_start(2'b00);
      for (int i = 0; i < FP - 1; i++) begin
         b = 8'(i + 1);
         req({b, b, b});
      end
      check("done_before_last", FRAME_DONE, 0);
      b = 8'(FP);
      req({b, b, b});
      check("done_set", FRAME_DONE, 1);
      check("done_state", dbg_state, 2);
      req_drop();
      req_drop();
      check("pops_done", rd_ptr, base + FP);
      check("done_held", FRAME_DONE, 1);

      // Frame sync mid-word with a coincident request and mode change
      flush();
      push_word(16'hFFFF);
      push_word(16'h1CF8);
      base = rd_ptr;
      frame_start(2'b01);
      repeat (5) req(24'hFFFFFF);
      PIXEL_MODE = 2'b11;
      FRAME_SYNC = 1'b1;
      PIX_REQ    = 1'b1;
      #1 check("rd_on_sync", WORD_RD, 0);
      tick();
      FRAME_SYNC = 1'b0;
      PIX_REQ    = 1'b0;
      check("pops_sync_drop", rd_ptr, base + 1);
      check("sync_valid_drop", oVALID, 0);
      tick();
      req(24'hFF00E7);
      check("pops_after_sync", rd_ptr, base + 2);

      // Reset mid-frame
      push_word(16'h1234);
      base = rd_ptr;
      RESET_N = 1'b0;
      PIX_REQ = 1'b1;
      #1 check("rd_in_reset", WORD_RD, 0);
      tick();
      PIX_REQ = 1'b0;
      check("mrst_rgb", {8'h0, oRED, oGREEN, oBLUE}, 32'h0);
      check("mrst_valid", oVALID, 0);
      check("mrst_state", dbg_state, 0);
      check("mrst_pops", rd_ptr, base);
      RESET_N = 1'b1;

      repeat (2) tick();
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
